// File: rtl/pio_mailbox_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pio_mailbox_responder                                        |
// | Description : FPGA-side responder for the host PIO mailbox. Captures a     |
// |               command word on a REQ toggle, executes it (7-seg, LEDs,      |
// |               button/switch readback) and returns a response word with a   |
// |               matching ACK toggle.                                         |
// |               Optional build macro: DEBOUNCE_EN (per-button debounce).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pio_mailbox_responder #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] cmd_word,
  output logic [31:0] rsp_word,
  input  logic [3:0]  buttons_n,
  input  logic [17:0] switches,
  output logic [31:0] hex_seg_n,
  output logic [17:0] ledr,
  output logic [8:0]  ledg,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [2:0] c_op_set_hex  = 3'd1;
  localparam logic [2:0] c_op_set_ledr = 3'd2;
  localparam logic [2:0] c_op_set_ledg = 3'd3;
  localparam logic [2:0] c_op_read_in  = 3'd4;
  localparam logic [2:0] c_op_echo     = 3'd5;

  state_t      r_state;
  logic        r_last_req;
  logic [31:0] r_cmd_q;
  logic [1:0]  r_digit;
  logic [31:0] r_shadow;
  logic [3:0]  r_btn_meta;
  logic [3:0]  r_btn_sync;
  logic [3:0]  w_btn;
  logic [2:0]  w_op;
  logic        w_err;
  logic [26:0] w_data;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble
  function automatic logic [6:0] f_seg7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Two-flop synchroniser for the asynchronous active-low buttons (idle = released)
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_btn_meta <= 4'hF;
      r_btn_sync <= 4'hF;
    end else begin
      r_btn_meta <= buttons_n;
      r_btn_sync <= r_btn_meta;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);

  for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;

    // A new level must persist for DEBOUNCE_CYCLES clocks; any bounce restarts the count
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else if (~r_btn_sync[gi] != r_level) begin
        if (r_cnt == c_cnt_w'(DEBOUNCE_CYCLES - 1)) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end

    assign w_btn[gi] = r_level;
  end
`else
  assign w_btn = ~r_btn_sync;
`endif

  assign w_op  = r_cmd_q[30:28];
  assign w_err = (w_op == 3'd6) || (w_op == 3'd7);

  // Response data field for the command held in cmd_q
  always_comb begin
    w_data = '0;
    case (w_op)
      c_op_set_hex:  w_data = {11'd0, r_cmd_q[15:0]};
      c_op_set_ledr: w_data = {9'd0, r_cmd_q[17:0]};
      c_op_set_ledg: w_data = {18'd0, r_cmd_q[8:0]};
      c_op_read_in:  w_data = {5'd0, w_btn, switches};
      c_op_echo:     w_data = r_cmd_q[26:0];
      default:       w_data = '0;
    endcase
  end

  // Mailbox sequencer: INIT -> IDLE -> EXEC -> RESP -> IDLE, all outputs registered
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state    <= ST_INIT;
      r_last_req <= 1'b0;
      r_cmd_q    <= '0;
      r_digit    <= '0;
      r_shadow   <= '1;
      rsp_word   <= '0;
      hex_seg_n  <= '1;
      ledr       <= '0;
      ledg       <= '0;
      busy       <= 1'b0;
    end else begin
      case (r_state)
        // Adopt whatever REQ is pending so a stale word is never replayed
        ST_INIT: begin
          r_last_req <= cmd_word[31];
          r_state    <= ST_IDLE;
        end
        ST_IDLE: begin
          if (cmd_word[31] != r_last_req) begin
            r_cmd_q    <= cmd_word;
            r_last_req <= cmd_word[31];
            r_digit    <= 2'd0;
            busy       <= 1'b1;
            r_state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_op == c_op_set_hex) begin
            r_shadow[{r_digit, 3'b000} +: 8] <= {1'b1, f_seg7(r_cmd_q[{r_digit, 2'b00} +: 4])};
            r_digit <= r_digit + 2'd1;
            if (r_digit == 2'd3) begin
              r_state <= ST_RESP;
            end
          end else begin
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          rsp_word <= {r_cmd_q[31], w_op, w_err, w_data};
          if (w_op == c_op_set_hex) begin
            hex_seg_n <= r_shadow;
          end
          if (w_op == c_op_set_ledr) begin
            ledr <= r_cmd_q[17:0];
          end
          if (w_op == c_op_set_ledg) begin
            ledg <= r_cmd_q[8:0];
          end
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pio_mailbox_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pio_mailbox_responder                                     |
// | Description : Self-checking bench for pio_mailbox_responder with a         |
// |               transaction-level model (latency + response rules) and a     |
// |               per-cycle compare process.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pio_mailbox_responder;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [31:0] cmd_word = 32'h0;
  logic [31:0] rsp_word;
  logic [3:0]  buttons_n = 4'hF;
  logic [17:0] switches = 18'h0;
  logic [31:0] hex_seg_n;
  logic [17:0] ledr;
  logic [8:0]  ledg;
  logic        busy;

  pio_mailbox_responder #(.DEBOUNCE_CYCLES(8)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .cmd_word      (cmd_word),
    .rsp_word      (rsp_word),
    .buttons_n     (buttons_n),
    .switches      (switches),
    .hex_seg_n     (hex_seg_n),
    .ledr          (ledr),
    .ledg          (ledg),
    .busy          (busy)
  );

  always #5 clk_clk = ~clk_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Count rising edges; sampled on falling edges
  always @(posedge clk_clk) cyc <= cyc + 1;

  // Model state: currently visible outputs and at most one command in flight
  logic [31:0] exp_rsp  = 32'h0;
  logic [31:0] exp_hex  = 32'hFFFF_FFFF;
  logic [17:0] exp_ledr = 18'h0;
  logic [8:0]  exp_ledg = 9'h0;
  bit          pend = 1'b0;
  int          pend_cap = 0;
  int          pend_due = 0;
  logic [31:0] pend_rsp;
  logic [31:0] pend_hex;
  logic [17:0] pend_ledr;
  logic [8:0]  pend_ledg;
  logic        m_req = 1'b0;
  logic [3:0]  m_btn = 4'h0;
  bit          chk_en = 1'b0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk_clk) begin
    if (chk_en) begin
      if (pend && cyc >= pend_due) begin
        exp_rsp  = pend_rsp;
        exp_hex  = pend_hex;
        exp_ledr = pend_ledr;
        exp_ledg = pend_ledg;
        pend     = 1'b0;
      end
      check("rsp_word",  rsp_word,          exp_rsp);
      check("hex_seg_n", hex_seg_n,         exp_hex);
      check("ledr",      {14'h0, ledr},     {14'h0, exp_ledr});
      check("ledg",      {23'h0, ledg},     {23'h0, exp_ledg});
      check("busy",      {31'h0, busy},     {31'h0, (pend && cyc >= pend_cap)});
    end
  end

  // Compute the response and output effects of a command from the opcode rules
  task automatic model_cmd(input logic [2:0] op, input logic [27:0] payload);
    logic [26:0] data;
    logic        err;
    int          nib;
    data      = '0;
    err       = 1'b0;
    pend_hex  = exp_hex;
    pend_ledr = exp_ledr;
    pend_ledg = exp_ledg;
    case (op)
      3'd1: begin
        for (int i = 0; i < 4; i++) begin
          nib = int'((payload >> (4 * i)) & 28'hF);
          pend_hex[8*i +: 8] = {1'b1, seg_tab[nib]};
        end
        data = 27'(payload & 28'hFFFF);
      end
      3'd2: begin pend_ledr = payload[17:0]; data = 27'(payload[17:0]); end
      3'd3: begin pend_ledg = payload[8:0];  data = 27'(payload[8:0]);  end
      3'd4: data = 27'(m_btn) * 27'd262144 + 27'(switches);
      3'd5: data = payload[26:0];
      3'd6, 3'd7: err = 1'b1;
      default: data = '0;
    endcase
    pend_rsp = {m_req, op, err, data};
  endtask

  // Toggle REQ with a new command; capture happens on the next rising edge
  task automatic issue(input logic [2:0] op, input logic [27:0] payload);
    @(negedge clk_clk); #1;
    m_req    = ~m_req;
    cmd_word = {m_req, op, payload};
    model_cmd(op, payload);
    pend_cap = cyc + 1;
    pend_due = cyc + ((op == 3'd1) ? 6 : 3);
    pend     = 1'b1;
  endtask

  task automatic do_reset(input logic [31:0] held_cmd);
    @(negedge clk_clk); #1;
    reset_reset_n = 1'b0;
    cmd_word = held_cmd;
    m_req    = held_cmd[31];
    pend     = 1'b0;
    exp_rsp  = 32'h0;
    exp_hex  = 32'hFFFF_FFFF;
    exp_ledr = 18'h0;
    exp_ledg = 9'h0;
    m_btn    = 4'h0;
    repeat (2) @(negedge clk_clk);
    #1 reset_reset_n = 1'b1;
    repeat (3) @(negedge clk_clk);
  endtask

  task automatic set_inputs(input logic [3:0] b_n, input logic [17:0] sw);
    @(negedge clk_clk); #1;
    buttons_n = b_n;
    switches  = sw;
    repeat (14) @(negedge clk_clk);
    m_btn = ~b_n;
  endtask

  initial begin
    cmd_word = 32'h8000_0000;
    m_req    = 1'b1;
    repeat (2) @(negedge clk_clk);
    chk_en = 1'b1;
    #1 reset_reset_n = 1'b1;
    // Stale pending REQ at reset release must not execute
    repeat (20) @(negedge clk_clk);
    check("t1 rsp after release", rsp_word, 32'h0);
    check("t1 busy after release", {31'h0, busy}, 32'h0);

    do_reset(32'h0);
    issue(3'd1, 28'h000_1234);
    repeat (8) @(negedge clk_clk);
    check("t2 hex", hex_seg_n, 32'hF9A4_B099);
    check("t2 rsp", rsp_word, 32'h9000_1234);

    issue(3'd2, 28'h003_FFFF);
    repeat (6) @(negedge clk_clk);
    check("t3 ledr", {14'h0, ledr}, 32'h0003_FFFF);
    check("t3 rsp", rsp_word, 32'h2003_FFFF);

    set_inputs(4'b1110, 18'h5);
    issue(3'd4, 28'h0);
    repeat (6) @(negedge clk_clk);
    check("t4 rsp", rsp_word, 32'hC004_0005);

    issue(3'd7, 28'h0);
    repeat (6) @(negedge clk_clk);
    check("t5 rsp", rsp_word, 32'h7800_0000);
    check("t5 hex", hex_seg_n, 32'hF9A4_B099);
    check("t5 ledr", {14'h0, ledr}, 32'h0003_FFFF);
    check("t5 ledg", {23'h0, ledg}, 32'h0);

    // Payload change without a REQ toggle is ignored
    @(negedge clk_clk); #1;
    cmd_word = {m_req, 3'd2, 28'h000_0123};
    repeat (10) @(negedge clk_clk);
    check("no-toggle ledr", {14'h0, ledr}, 32'h0003_FFFF);

    // Two REQ toggles while busy: the second cancels the first, no extra command
    issue(3'd3, 28'h000_01AB);
    @(negedge clk_clk); #1;
    cmd_word = {~m_req, 3'd2, 28'h000_0055};
    @(negedge clk_clk); #1;
    cmd_word = {m_req, 3'd2, 28'h000_0077};
    repeat (10) @(negedge clk_clk);
    check("dbl-toggle ledg", {23'h0, ledg}, 32'h0000_01AB);
    check("dbl-toggle ledr", {14'h0, ledr}, 32'h0003_FFFF);

    // Randomised command stream
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0)
        set_inputs(4'($urandom_range(0, 15)), 18'($urandom));
      issue(3'($urandom_range(0, 7)), 28'($urandom));
      repeat (7 + $urandom_range(0, 3)) @(negedge clk_clk);
    end

`ifdef DEBOUNCE_EN
    set_inputs(4'hF, 18'h0);
    // Short glitch is filtered
    @(negedge clk_clk); #1 buttons_n = 4'hE;
    issue(3'd4, 28'h0);
    repeat (4) @(negedge clk_clk);
    #1 buttons_n = 4'hF;
    repeat (6) @(negedge clk_clk);
    check("glitch btn0", rsp_word & 32'h0004_0000, 32'h0);
    // Long press is accepted
    @(negedge clk_clk); #1 buttons_n = 4'hE;
    repeat (11) @(negedge clk_clk);
    m_btn = 4'h1;
    issue(3'd4, 28'h0);
    repeat (6) @(negedge clk_clk);
    check("press btn0", rsp_word & 32'h0004_0000, 32'h0004_0000);
    set_inputs(4'hF, 18'h0);
`endif

    // Reset during SET_HEX execution aborts it without a response
    issue(3'd1, 28'h000_ABCD);
    repeat (3) @(negedge clk_clk);
    do_reset(cmd_word);
    repeat (10) @(negedge clk_clk);
    check("abort hex", hex_seg_n, 32'hFFFF_FFFF);
    check("abort rsp", rsp_word, 32'h0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
